// File: rtl/detect_rr_scheduler.sv
// Round-robin scheduler sharing one bit-serial overlapping "101" Moore detector
// among N_REQ parallel requesters; reports match count and served ID per word.
module detect_rr_scheduler #(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned ID_W  = $clog2(N_REQ),
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]       o_gnt,
  output logic                   o_busy,
  output logic                   o_hit,
  output logic                   o_done,
  output logic [ID_W-1:0]        o_id,
  output logic [CNT_W-1:0]       o_count
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Gray-coded detector states
  localparam logic [1:0] D_S0 = 2'b00;
  localparam logic [1:0] D_S1 = 2'b01;
  localparam logic [1:0] D_S2 = 2'b11;
  localparam logic [1:0] D_S3 = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [1:0]       det_q, det_nx;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] match_cnt_q;
  logic [ID_W-1:0]  srv_id_q;
  logic [ID_W-1:0]  ptr_q;

  logic             win_found;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W:0]    cand;
  logic [N_REQ-1:0] gnt_c;
  logic             last_bit;
  logic             hit_nx;

  // Rotating-priority search starting one past the last granted requester
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (ID_W+1)'(ptr_q) + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!win_found && i_req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Detector transition function; illegal codes fall back to S0
  always_comb begin
    det_nx = D_S0;
    unique case (det_q)
      D_S0:    det_nx = shreg_q[WIDTH-1] ? D_S1 : D_S0;
      D_S1:    det_nx = shreg_q[WIDTH-1] ? D_S1 : D_S2;
      D_S2:    det_nx = shreg_q[WIDTH-1] ? D_S3 : D_S0;
      D_S3:    det_nx = shreg_q[WIDTH-1] ? D_S1 : D_S2;
      default: det_nx = D_S0;
    endcase
  end

  assign hit_nx   = (det_nx == D_S3);
  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_c   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d        = ST_SHIFT;
          gnt_c[win_idx] = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (last_bit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grant is visible only out of reset so every output reads 0 while reset is held
  assign o_gnt = i_rst_n ? gnt_c : '0;

  // Datapath: word capture, serialization, match counting and result latching
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shreg_q     <= '0;
      det_q       <= D_S0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      srv_id_q    <= '0;
      ptr_q       <= ID_W'(N_REQ - 1);
      o_id        <= '0;
      o_count     <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            shreg_q     <= i_data[int'(win_idx)*WIDTH +: WIDTH];
            det_q       <= D_S0;
            bit_cnt_q   <= '0;
            match_cnt_q <= '0;
            srv_id_q    <= win_idx;
            ptr_q       <= win_idx;
          end
        end
        ST_SHIFT: begin
          det_q     <= det_nx;
          shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (hit_nx) begin
            match_cnt_q <= match_cnt_q + CNT_W'(1);
          end
          if (last_bit) begin
            o_count <= match_cnt_q + CNT_W'(hit_nx);
            o_id    <= srv_id_q;
          end
        end
        ST_DONE: begin
          // Return detector to S0 so o_hit reads 0 in IDLE
          det_q <= D_S0;
        end
        default: begin
          det_q <= D_S0;
        end
      endcase
    end
  end

  assign o_busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign o_done = (state_q == ST_DONE);
  assign o_hit  = (det_q == D_S3);

endmodule

// File: tb/tb_detect_rr_scheduler.sv
// Scoreboard bench for detect_rr_scheduler: directed words with hand-computed
// match counts; a monitor pops expected grants/results as the DUT presents them.
module tb_detect_rr_scheduler;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;

  logic               i_clk;
  logic               i_rst_n;
  logic [N_REQ-1:0]   i_req;
  logic [N_REQ*WIDTH-1:0] i_data;
  logic [N_REQ-1:0]   o_gnt;
  logic               o_busy;
  logic               o_hit;
  logic               o_done;
  logic [1:0]         o_id;
  logic [3:0]         o_count;

  detect_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .i_data  (i_data),
    .o_gnt   (o_gnt),
    .o_busy  (o_busy),
    .o_hit   (o_hit),
    .o_done  (o_done),
    .o_id    (o_id),
    .o_count (o_count)
  );

  typedef struct {
    int id;
    int cnt;
    bit hit;
  } exp_t;

  logic [3:0] exp_gnt[$];
  exp_t       exp_done[$];

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  gnt_cyc  = 0;
  bit  chk_spacing = 1'b0;
  bit  spacing_armed = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
  endtask

  // Monitor: compare each grant and each result against the scoreboard
  always @(negedge i_clk) begin
    exp_t e;
    logic [3:0] g;
    cyc++;
    if (o_gnt != '0) begin
      if (exp_gnt.size() == 0) begin
        check("unexpected_gnt", 32'(o_gnt), 32'h0);
      end else begin
        g = exp_gnt.pop_front();
        check("gnt", 32'(o_gnt), 32'(g));
      end
      if (chk_spacing && spacing_armed) check("gnt_spacing", 32'(cyc - gnt_cyc), 32'd10);
      spacing_armed = chk_spacing;
      gnt_cyc = cyc;
    end
    if (o_done) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 32'(o_done), 32'h0);
      end else begin
        e = exp_done.pop_front();
        check("id", 32'(o_id), 32'(e.id));
        check("count", 32'(o_count), 32'(e.cnt));
        check("hit_in_done", 32'(o_hit), 32'(e.hit));
        check("latency", 32'(cyc - gnt_cyc), 32'd9);
      end
    end
  end

  task automatic wait_gnt(input int k);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_gnt[k]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("wait_gnt");
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout("wait_done");
  endtask

  task automatic push_exp(input int k, input int cnt, input bit hit);
    exp_t e;
    logic [3:0] g;
    g = 4'b0001 << k;
    e.id = k;
    e.cnt = cnt;
    e.hit = hit;
    exp_gnt.push_back(g);
    exp_done.push_back(e);
  endtask

  // One word from requester k, start to finish, then confirm the IDLE cycle
  task automatic serve(input int k, input logic [7:0] d, input int cnt, input bit hit);
    push_exp(k, cnt, hit);
    @(posedge i_clk); #1;
    i_data[k*WIDTH +: WIDTH] = d;
    i_req[k] = 1'b1;
    wait_gnt(k);
    @(posedge i_clk); #1;
    i_req[k] = 1'b0;
    wait_done();
    @(negedge i_clk);
    check("idle_busy", 32'(o_busy), 32'h0);
    check("idle_hit", 32'(o_hit), 32'h0);
  endtask

  initial begin
    int ngr;
    i_rst_n = 1'b0;
    i_req   = '0;
    i_data  = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_gnt", 32'(o_gnt), 32'h0);
    check("rst_busy", 32'(o_busy), 32'h0);
    check("rst_done", 32'(o_done), 32'h0);
    check("rst_count", 32'(o_count), 32'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Single word, then three words on req1, then cross-word boundary pair
    serve(0, 8'b1010_1101, 3, 1'b1);
    serve(1, 8'h00, 0, 1'b0);
    serve(1, 8'hFF, 0, 1'b0);
    serve(1, 8'hAA, 3, 1'b0);
    serve(2, 8'h02, 0, 1'b0);
    serve(2, 8'h80, 0, 1'b0);

    // req2 raised while busy: no grant until IDLE
    push_exp(1, 2, 1'b0);
    push_exp(2, 1, 1'b1);
    @(posedge i_clk); #1;
    i_data[1*WIDTH +: WIDTH] = 8'h5A;
    i_data[2*WIDTH +: WIDTH] = 8'h05;
    i_req[1] = 1'b1;
    wait_gnt(1);
    @(posedge i_clk); #1;
    i_req[1] = 1'b0;
    i_req[2] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      if (!o_busy) break;
      check("gnt_while_busy", 32'(o_gnt), 32'h0);
    end
    check("gnt_first_idle", 32'(o_gnt), 32'h4);
    @(posedge i_clk); #1;
    i_req[2] = 1'b0;
    wait_done();
    @(negedge i_clk);

    // All requesters held from reset: 0,1,2,3,0 every 10 cycles
    i_rst_n = 1'b0;
    i_data = {8'hFF, 8'hAA, 8'h00, 8'hAD};
    i_req = 4'hF;
    push_exp(0, 3, 1'b1);
    push_exp(1, 0, 1'b0);
    push_exp(2, 3, 1'b0);
    push_exp(3, 0, 1'b0);
    push_exp(0, 3, 1'b1);
    #1;
    check("gnt_in_reset", 32'(o_gnt), 32'h0);
    chk_spacing = 1'b1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    ngr = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_gnt != '0) ngr++;
      if (ngr == 5) break;
    end
    if (ngr != 5) timeout("rr_grants");
    @(posedge i_clk); #1;
    i_req = '0;
    chk_spacing = 1'b0;
    wait_done();
    @(negedge i_clk);

    // Reset during the 4th SHIFT cycle discards the word
    exp_gnt.push_back(4'b1000);
    @(posedge i_clk); #1;
    i_data[3*WIDTH +: WIDTH] = 8'h25;
    i_req[3] = 1'b1;
    wait_gnt(3);
    @(posedge i_clk); #1;
    i_req[0] = 1'b1;
    repeat (3) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(o_gnt), 32'h0);
    check("mid_rst_busy", 32'(o_busy), 32'h0);
    check("mid_rst_hit", 32'(o_hit), 32'h0);
    check("mid_rst_done", 32'(o_done), 32'h0);
    check("mid_rst_id", 32'(o_id), 32'h0);
    check("mid_rst_count", 32'(o_count), 32'h0);
    push_exp(0, 3, 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    wait_gnt(0);
    @(posedge i_clk); #1;
    i_req[0] = 1'b0;
    wait_done();
    push_exp(3, 1, 1'b1);
    wait_gnt(3);
    @(posedge i_clk); #1;
    i_req[3] = 1'b0;
    wait_done();

    repeat (3) @(negedge i_clk);
    check("gnt_queue_empty", 32'(exp_gnt.size()), 32'h0);
    check("done_queue_empty", 32'(exp_done.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
